booth_r4_mul_seq: RTL and testbench

//   Parametrised sequential radix-4 Booth multiplier; next generation of the 8-bit Booth multiplier.

---
 rtl/booth_r4_mul_seq.sv | 145 ++++++++++++++
 tb/tb_booth_r4_mul_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_r4_mul_seq.sv
// Sequential radix-4 Booth multiplier with runtime signed/unsigned mode and
// valid/ready handshakes. One operation in flight; WIDTH/2+1 recoding steps.
module booth_r4_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic [2*WIDTH-1:0] p,
  output logic               rdy,
  input  logic               out_ready
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int EXTW = WIDTH + 2;
  localparam int ACCW = 2 * WIDTH + 2;
  localparam int CNTW = $clog2(ITER + 1);
  localparam logic [CNTW-1:0] LAST_STEP = CNTW'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACCW-1:0]    mcand_q, mcand_d;
  logic [EXTW-1:0]    mplier_q, mplier_d;
  logic               prev_q, prev_d;
  logic [ACCW-1:0]    acc_q, acc_d;
  logic [CNTW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               rdy_q, rdy_d;
  logic               in_ready_q, in_ready_d;

  logic [ACCW-1:0]    a_ext;
  logic [EXTW-1:0]    b_ext;
  logic [2:0]         triplet;
  logic [ACCW-1:0]    mcand_x2;
  logic [ACCW-1:0]    addend;
  logic [ACCW-1:0]    acc_sum;

  always_comb begin
    a_ext = sgn ? {{(ACCW - WIDTH){a[WIDTH-1]}}, a} : {{(ACCW - WIDTH){1'b0}}, a};
    b_ext = sgn ? {{(EXTW - WIDTH){b[WIDTH-1]}}, b} : {{(EXTW - WIDTH){1'b0}}, b};
  end

  // The multiplicand is pre-shifted by 2 each step and the multiplier shifted
  // right, so the current triplet is always the low two bits plus the saved bit.
  always_comb begin
    triplet  = {mplier_q[1:0], prev_q};
    mcand_x2 = {mcand_q[ACCW-2:0], 1'b0};
    addend   = '0;
    unique case (triplet)
      3'b001, 3'b010: addend = mcand_q;
      3'b011:         addend = mcand_x2;
      3'b100:         addend = ~mcand_x2 + ACCW'(1);
      3'b101, 3'b110: addend = ~mcand_q + ACCW'(1);
      default:        addend = '0;
    endcase
    acc_sum = acc_q + addend;
  end

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    prev_d     = prev_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    rdy_d      = rdy_q;
    in_ready_d = in_ready_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mcand_d    = a_ext;
          mplier_d   = b_ext;
          prev_d     = 1'b0;
          acc_d      = '0;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[ACCW-3:0], 2'b00};
        mplier_d = {2'b00, mplier_q[EXTW-1:2]};
        prev_d   = mplier_q[1];
        cnt_d    = cnt_q + CNTW'(1);
        if (cnt_q == LAST_STEP) begin
          p_d     = acc_sum[2*WIDTH-1:0];
          rdy_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          rdy_d      = 1'b0;
          in_ready_d = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: begin
        rdy_d      = 1'b0;
        in_ready_d = 1'b1;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      mcand_q    <= '0;
      mplier_q   <= '0;
      prev_q     <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      p_q        <= '0;
      rdy_q      <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      mcand_q    <= mcand_d;
      mplier_q   <= mplier_d;
      prev_q     <= prev_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      rdy_q      <= rdy_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign p        = p_q;
  assign rdy      = rdy_q;
  assign in_ready = in_ready_q;

endmodule

// File: tb/tb_booth_r4_mul_seq.sv
// Bench for booth_r4_mul_seq: table vectors, random ops against a plain
// integer-multiply model, back-pressure and mid-operation reset sequences.
module tb_booth_r4_mul_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, sgn, rdy, out_ready;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        in_valid16, in_ready16, sgn16, rdy16, out_ready16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  booth_r4_mul_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .p(p), .rdy(rdy), .out_ready(out_ready)
  );

  booth_r4_mul_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .sgn(sgn16), .p(p16), .rdy(rdy16), .out_ready(out_ready16)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] p;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
    longint xv, yv;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    return 16'(xv * yv);
  endfunction

  function automatic logic [31:0] model16(input logic [15:0] x, input logic [15:0] y, input logic s);
    longint xv, yv;
    xv = s ? longint'($signed(x)) : longint'(x);
    yv = s ? longint'($signed(y)) : longint'(y);
    return 32'(xv * yv);
  endfunction

  // One full 8-bit transaction: accept, wait for rdy, hold for `hold` cycles, handshake.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic ts,
                      input int hold, input bit noisy,
                      output logic [15:0] pr, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb; sgn = ts; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = noisy ? 1'($urandom) : 1'b0;
    a = 8'($urandom); b = 8'($urandom); sgn = 1'($urandom);
    check("in_ready_busy", in_ready, 0);
    lat = 0;
    while (!rdy && lat < 40) begin
      if (noisy) out_ready = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    out_ready = 1'b0;
    pr = p;
    for (int i = 0; i < hold; i++) begin
      in_valid = noisy ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      check("hold_rdy", rdy, 1);
      check("hold_p", p, pr);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_hs_rdy", rdy, 0);
    check("post_hs_in_ready", in_ready, 1);
  endtask

  task automatic run16(input logic [15:0] ta, input logic [15:0] tb, input logic ts,
                       output logic [31:0] pr, output int lat);
    @(negedge clk);
    check("in_ready16_idle", in_ready16, 1);
    a16 = ta; b16 = tb; sgn16 = ts; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    lat = 0;
    while (!rdy16 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    pr = p16;
    out_ready16 = 1'b1;
    @(posedge clk); #1;
    out_ready16 = 1'b0;
    check("post_hs16_rdy", rdy16, 0);
  endtask

  initial begin
    vec_t        vecs[10];
    logic [15:0] pr;
    logic [31:0] pr16;
    logic [7:0]  ra, rb;
    logic        rs;
    int          lat;

    vecs[0] = '{8'h81, 8'h89, 1'b1, 16'h3B09};
    vecs[1] = '{8'hB9, 8'hA1, 1'b1, 16'h1A59};
    vecs[2] = '{8'h29, 8'h99, 1'b1, 16'hEF81};
    vecs[3] = '{8'h80, 8'h80, 1'b1, 16'h4000};
    vecs[4] = '{8'h00, 8'hCD, 1'b1, 16'h0000};
    vecs[5] = '{8'hFF, 8'hFF, 1'b0, 16'hFE01};
    vecs[6] = '{8'h81, 8'h89, 1'b0, 16'h4509};
    vecs[7] = '{8'hFF, 8'hFF, 1'b1, 16'h0001};
    vecs[8] = '{8'h7F, 8'h80, 1'b1, 16'hC080};
    vecs[9] = '{8'h7F, 8'h7F, 1'b0, 16'h3F01};

    reset = 1'b0;
    in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; out_ready = 1'b0;
    in_valid16 = 1'b0; a16 = '0; b16 = '0; sgn16 = 1'b0; out_ready16 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_rdy", rdy, 0);
    check("reset_p", p, 0);
    check("reset_p16", p16, 0);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      run8(vecs[i].a, vecs[i].b, vecs[i].s, 1, 1'b0, pr, lat);
      check($sformatf("vec%0d_p", i), pr, vecs[i].p);
      check($sformatf("vec%0d_lat", i), 64'(lat), 64'd5);
    end

    run16(16'h8000, 16'h8000, 1'b1, pr16, lat);
    check("w16_signed_p", pr16, 32'h4000_0000);
    check("w16_signed_lat", 64'(lat), 64'd9);
    run16(16'hFFFF, 16'h0002, 1'b0, pr16, lat);
    check("w16_unsigned_p", pr16, 32'h0001_FFFE);
    for (int i = 0; i < 40; i++) begin
      logic [15:0] x, y;
      x = 16'($urandom); y = 16'($urandom); rs = 1'($urandom);
      run16(x, y, rs, pr16, lat);
      check("w16_rand_p", pr16, model16(x, y, rs));
    end

    for (int i = 0; i < 300; i++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
      run8(ra, rb, rs, int'($urandom_range(0, 2)), 1'b1, pr, lat);
      check("rand_p", pr, model8(ra, rb, rs));
      check("rand_lat", 64'(lat), 64'd5);
    end

    // Long back-pressure with stray in_valid, then the next op must still go through.
    run8(8'h93, 8'h5A, 1'b1, 20, 1'b1, pr, lat);
    check("bp_p", pr, model8(8'h93, 8'h5A, 1'b1));
    run8(8'h12, 8'h34, 1'b0, 0, 1'b0, pr, lat);
    check("bp_next_p", pr, 16'h03A8);

    // Reset in the third CALC cycle aborts the op and clears p.
    @(negedge clk);
    a = 8'h55; b = 8'h66; sgn = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_rdy", rdy, 0);
    check("rst_p", p, 0);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("rst_no_result", rdy, 0);
    end
    run8(8'hC3, 8'h3C, 1'b1, 0, 1'b0, pr, lat);
    check("rst_next_p", pr, model8(8'hC3, 8'h3C, 1'b1));
    check("rst_next_lat", 64'(lat), 64'd5);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
